// File: rtl/platform_switch_debounce_ctrl_if.sv
// Avalon-MM slave bus bundle for the switch debounce controller.
// The master drives the address and write strobes; the slave returns registered read data.
interface platform_switch_debounce_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/platform_switch_debounce_ctrl.sv
// Slide-switch controller: two-flop synchroniser, tick-based per-bit debounce,
// edge capture with write-1-to-clear, and a maskable level irq behind an Avalon-MM slave.
module platform_switch_debounce_ctrl #(
  parameter int unsigned WIDTH        = 10,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_TICKS = 8,
  parameter int unsigned EDGE_TYPE    = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  platform_switch_debounce_ctrl_if.slave bus,
  input  logic [WIDTH-1:0]               in_port,
  output logic                           irq
);
  localparam int unsigned DivW = $clog2(TICK_DIV);
  localparam int unsigned CntW = $clog2(STABLE_TICKS + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync_meta_q, sync_q;
  logic [WIDTH-1:0] deb_q, deb_d, deb_dly_q;
  logic [WIDTH-1:0] edge_q, edge_d, edge_ev, clr;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             tick;
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_d;
  logic             write_en;
  logic             unused_wdata;

  assign write_en     = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata;
  assign bus.readdata = rdata_q;

  always_comb begin
    tick  = (div_q == DivLast);
    div_d = tick ? '0 : div_q + DivW'(1);
  end

  // Counter only advances on ticks while the synced level disagrees; any agreement clears it.
  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (!tick) begin
          cnt_d[i] = cnt_q[i];
        end else if (cnt_q[i] == CntLast) begin
          deb_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_comb begin
    if (EDGE_TYPE == 1) begin
      edge_ev = deb_q & ~deb_dly_q;
    end else if (EDGE_TYPE == 2) begin
      edge_ev = ~deb_q & deb_dly_q;
    end else begin
      edge_ev = deb_q ^ deb_dly_q;
    end
    clr    = (write_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
    // A fresh edge overrides a simultaneous clear of the same bit.
    edge_d = (edge_q & ~clr) | edge_ev;
    mask_d = (write_en && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : mask_q;
    irq_d  = |(edge_q & mask_q);
  end

  always_comb begin
    rdata_d = '0;
    unique case (bus.address)
      2'd0: rdata_d[WIDTH-1:0] = deb_q;
      2'd1: rdata_d[WIDTH-1:0] = sync_q;
      2'd2: rdata_d[WIDTH-1:0] = mask_q;
      2'd3: rdata_d[WIDTH-1:0] = edge_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
      deb_q       <= '0;
      deb_dly_q   <= '0;
      edge_q      <= '0;
      mask_q      <= '0;
      div_q       <= '0;
      rdata_q     <= '0;
      irq         <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_meta_q <= in_port;
      sync_q      <= sync_meta_q;
      deb_q       <= deb_d;
      deb_dly_q   <= deb_q;
      edge_q      <= edge_d;
      mask_q      <= mask_d;
      div_q       <= div_d;
      rdata_q     <= rdata_d;
      irq         <= irq_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
endmodule

// File: tb/tb_platform_switch_debounce_ctrl.sv
// Self-checking bench for the switch debounce controller: directed vector table,
// hand-written corner sequences and a randomized run against a behavioural model.
module tb_platform_switch_debounce_ctrl;
  localparam int W  = 10;
  localparam int D  = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_port = '0;
  logic         irq;

  platform_switch_debounce_ctrl_if bus ();

  platform_switch_debounce_ctrl #(
    .WIDTH       (W),
    .TICK_DIV    (D),
    .STABLE_TICKS(ST),
    .EDGE_TYPE   (0)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .in_port(in_port),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a bit is accepted once the synced level has disagreed with the
  // debounced level for a run containing ST ticks; ticks fall on cycles n with n%D==D-1.
  logic [W-1:0] m_meta, m_sync, m_deb, m_debq, m_edge, m_mask, t_deb, t_clr;
  logic         m_irq, t_tick;
  logic [31:0]  m_rd;
  int           m_n;
  int           ds [W];

  function automatic int ticks_in(input int a, input int b);
    return (b + 1) / D - a / D;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_meta = '0; m_sync = '0; m_deb = '0; m_debq = '0; m_edge = '0; m_mask = '0;
        m_irq = 1'b0; m_rd = '0; m_n = 0;
        for (int i = 0; i < W; i++) ds[i] = -1;
      end else begin
        t_tick = (m_n % D) == D - 1;
        t_deb  = m_deb;
        for (int i = 0; i < W; i++) begin
          if (m_sync[i] != m_deb[i]) begin
            if (ds[i] < 0) ds[i] = m_n;
            if (t_tick && ticks_in(ds[i], m_n) == ST) begin
              t_deb[i] = m_sync[i];
              ds[i] = -1;
            end
          end else begin
            ds[i] = -1;
          end
        end
        t_clr = (bus.chipselect && !bus.write_n && bus.address == 2'd3) ?
                bus.writedata[W-1:0] : '0;
        case (bus.address)
          2'd0:    m_rd = {22'b0, m_deb};
          2'd1:    m_rd = {22'b0, m_sync};
          2'd2:    m_rd = {22'b0, m_mask};
          default: m_rd = {22'b0, m_edge};
        endcase
        m_irq  = |(m_edge & m_mask);
        m_edge = (m_edge & ~t_clr) | (m_deb ^ m_debq);
        if (bus.chipselect && !bus.write_n && bus.address == 2'd2) m_mask = bus.writedata[W-1:0];
        m_debq = m_deb;
        m_deb  = t_deb;
        m_sync = m_meta;
        m_meta = in_port;
        m_n++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (run_chk && !reset) begin
        check("model_readdata", bus.readdata, m_rd);
        check("model_irq", {31'b0, irq}, {31'b0, m_irq});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [W-1:0] inp;
    logic         wr;
    logic [1:0]   waddr;
    logic [31:0]  wdata;
    logic [1:0]   raddr;
    int           waitc;
    logic [31:0]  exp_rd;
    logic         exp_irq;
  } vec_t;

  vec_t vecs [8];

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  int  first;
  bit  found;
  int  r;

  initial begin
    vecs[0] = '{10'h000, 1'b0, 2'd0, 32'h0, 2'd0, 2,  32'h0, 1'b0};
    vecs[1] = '{10'h000, 1'b0, 2'd0, 32'h0, 2'd2, 2,  32'h0, 1'b0};
    vecs[2] = '{10'h000, 1'b0, 2'd0, 32'h0, 2'd3, 2,  32'h0, 1'b0};
    vecs[3] = '{10'h005, 1'b0, 2'd0, 32'h0, 2'd1, 3,  32'h5, 1'b0};
    vecs[4] = '{10'h005, 1'b0, 2'd0, 32'h0, 2'd0, 14, 32'h5, 1'b0};
    vecs[5] = '{10'h005, 1'b0, 2'd0, 32'h0, 2'd3, 1,  32'h5, 1'b0};
    vecs[6] = '{10'h005, 1'b1, 2'd2, 32'h1, 2'd2, 2,  32'h1, 1'b1};
    vecs[7] = '{10'h005, 1'b1, 2'd3, 32'h1, 2'd3, 2,  32'h4, 1'b0};

    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    run_chk = 1'b1;

    for (int v = 0; v < 8; v++) begin
      in_port = vecs[v].inp;
      if (vecs[v].wr) do_write(vecs[v].waddr, vecs[v].wdata);
      bus.address = vecs[v].raddr;
      repeat (vecs[v].waitc) @(negedge clk);
      check($sformatf("vec%0d_readdata", v), bus.readdata, vecs[v].exp_rd);
      check($sformatf("vec%0d_irq", v), {31'b0, irq}, {31'b0, vecs[v].exp_irq});
    end

    // Glitch on bit 3 shorter than the acceptance window.
    in_port = 10'h00D;
    bus.address = 2'd0;
    repeat (6) @(negedge clk);
    in_port = 10'h005;
    repeat (20) @(negedge clk);
    check("glitch_deb", bus.readdata, 32'h5);
    bus.address = 2'd3;
    @(negedge clk);
    check("glitch_edge", bus.readdata, 32'h4);

    // Clear of bit 1 in the same cycle its new edge is captured.
    in_port = 10'h007;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (m_deb[1] && !m_debq[1]) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("collision_wait", {31'b0, found}, 32'h1);
    do_write(2'd3, 32'h2);
    bus.address = 2'd3;
    @(negedge clk);
    check("collision_edge_kept", bus.readdata, 32'h6);
    do_write(2'd3, 32'h2);
    @(negedge clk);
    check("collision_then_clear", bus.readdata, 32'h4);

    // Reset in the middle of a debounce window with irq asserted.
    do_write(2'd2, 32'h3FF);
    @(negedge clk);
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    in_port = 10'h000;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    in_port = 10'h005;
    repeat (2) @(negedge clk);
    bus.address = 2'd0;
    reset = 1'b0;
    first = 99;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.readdata == 32'h5) begin
        first = k;
        break;
      end
    end
    check("latency_not_before_11", {31'b0, (first - 1) >= 11}, 32'h1);
    check("latency_within_14", {31'b0, (first - 1) <= 14}, 32'h1);
    bus.address = 2'd2;
    @(negedge clk);
    check("post_reset_mask", bus.readdata, 32'h0);

    // Randomized traffic against the model.
    for (int it = 0; it < 1500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 3) in_port = W'($urandom);
      else if (r < 6) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
      bus.address = 2'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = $urandom;
      end else begin
        bus.chipselect = 1'($urandom);
        bus.write_n    = 1'b1;
        bus.writedata  = $urandom;
      end
      @(negedge clk);
    end
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
